csr_trap_unit: RTL and testbench

- Machine-mode CSR file and trap controller for the 3-stage pipeline.
- Produces the `epc` / `epc_taken` redirect pair consumed by the next-PC select logic.
  - On interrupt entry, `epc` carries the trap vector.
  - On `mret`, `epc` carries the saved `mepc`.
- Also serves csrrw/csrrs/csrrc for the execute stage and asserts `flush` to kill the instruction being replaced.

---
 rtl/csr_pkg.sv | 35 +++
 rtl/irq_sync.sv | 23 ++
 rtl/csr_trap_unit.sv | 154 +++++++++++++++
 tb/tb_csr_trap_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encodings, cause codes and bit positions for the
// machine-mode CSR file and trap controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_EXT   = 4'd11;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MTI_BIT          = 7;
  localparam int unsigned MEI_BIT          = 11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } trap_state_e;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser bringing an asynchronous interrupt line into clk.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: serves csrrw/rs/rc, takes
// timer/external interrupts, handles mret and drives the PC redirect pair.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_exe,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            is_mret,
  input  logic            br_true,
  input  logic            jump_en,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] epc,
  output logic            epc_taken,
  output logic            flush
);

  trap_state_e     state_q;
  logic            mie_q, mpie_q;
  logic            mtie_q, meie_q;
  logic            mtip_q, meip_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mscratch_q;
  logic            ext_irq_s;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_irq),
    .sync_out (ext_irq_s)
  );

  logic [XLEN-1:0] mstatus_v, mie_v, mip_v;

  // Assemble the sparse CSRs; unimplemented bits read 0.
  always_comb begin
    mstatus_v                   = '0;
    mstatus_v[MSTATUS_MIE_BIT]  = mie_q;
    mstatus_v[MSTATUS_MPIE_BIT] = mpie_q;
    mie_v                       = '0;
    mie_v[MTI_BIT]              = mtie_q;
    mie_v[MEI_BIT]              = meie_q;
    mip_v                       = '0;
    mip_v[MTI_BIT]              = mtip_q;
    mip_v[MEI_BIT]              = meip_q;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_v;
      CSR_MIE:      csr_rdata = mie_v;
      CSR_MIP:      csr_rdata = mip_v;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      default:      csr_rdata = '0;
    endcase
  end

  csr_op_e         op;
  logic            run_ok, ext_pend, tmr_pend, trap_take, mret_take, csr_we;
  logic [3:0]      cause;
  logic [XLEN-1:0] csr_new, trap_vec;

  always_comb begin
    op        = csr_op_e'(csr_op);
    run_ok    = (state_q == RUN) && instr_valid && !br_true && !jump_en;
    ext_pend  = meip_q && meie_q;
    tmr_pend  = mtip_q && mtie_q;
    trap_take = run_ok && mie_q && !is_mret && (ext_pend || tmr_pend);
    mret_take = run_ok && is_mret;
    cause     = ext_pend ? CAUSE_EXT : CAUSE_TIMER;
    csr_we    = instr_valid && (state_q == RUN) && (op != CSR_NONE) && !trap_take;

    csr_new = csr_rdata;
    case (op)
      CSR_RW:  csr_new = csr_wdata;
      CSR_RS:  csr_new = csr_rdata | csr_wdata;
      CSR_RC:  csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase

    trap_vec = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[1:0] == MTVEC_VECTORED) begin
      trap_vec = trap_vec + XLEN'({cause, 2'b00});
    end

    epc_taken = trap_take || mret_take;
    flush     = trap_take || mret_take || (state_q == TRAP);
    epc       = trap_take ? trap_vec : mepc_q;
  end

  // CSR state, mip sampling and trap/mret sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else begin
      mtip_q <= timer_irq;
      meip_q <= ext_irq_s;

      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= csr_new[MSTATUS_MIE_BIT];
            mpie_q <= csr_new[MSTATUS_MPIE_BIT];
          end
          CSR_MIE: begin
            mtie_q <= csr_new[MTI_BIT];
            meie_q <= csr_new[MEI_BIT];
          end
          CSR_MTVEC:    mtvec_q    <= csr_new;
          CSR_MEPC:     mepc_q     <= {csr_new[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= csr_new;
          CSR_MSCRATCH: mscratch_q <= csr_new;
          default: ;
        endcase
      end

      if (trap_take) begin
        mepc_q   <= pc_exe;
        mcause_q <= {1'b1, {(XLEN-5){1'b0}}, cause};
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
        state_q  <= TRAP;
      end else if (mret_take) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (state_q == TRAP) begin
        state_q <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit with a queue-based expected-value scoreboard.
module tb_csr_trap_unit;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned XLEN        = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid;
  logic [XLEN-1:0] pc_exe;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            is_mret, br_true, jump_en, timer_irq, ext_irq;
  logic [XLEN-1:0] csr_rdata, epc;
  logic            epc_taken, flush;

  csr_trap_unit #(.SYNC_STAGES(SYNC_STAGES), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .pc_exe      (pc_exe),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .is_mret     (is_mret),
    .br_true     (br_true),
    .jump_en     (jump_en),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .epc         (epc),
    .epc_taken   (epc_taken),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          errs    = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic compare(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      errs++;
      $error("FAIL sb_empty: got %h expected nothing queued", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
    csr_op   = 2'b00;
    csr_addr = a;
    expect_v(tag, e);
    #1;
    compare(csr_rdata);
    tick();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    instr_valid = 1'b1;
    csr_op      = op;
    csr_addr    = a;
    csr_wdata   = d;
    tick();
    instr_valid = 1'b0;
    csr_op      = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n = 1'b0; instr_valid = 1'b0; pc_exe = '0; csr_op = 2'b00;
    csr_addr = '0; csr_wdata = '0; is_mret = 1'b0; br_true = 1'b0;
    jump_en = 1'b0; timer_irq = 1'b0; ext_irq = 1'b1;

    // Reset with ext_irq high
    tick();
    expect_v("rst_epc_taken", 0); expect_v("rst_flush", 0); expect_v("rst_epc", 0);
    #1;
    compare(32'(epc_taken)); compare(32'(flush)); compare(epc);
    tick();
    rst_n = 1'b1;
    rd("rst_mip", 12'h344, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mie", 12'h304, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);
    instr_valid = 1'b1; pc_exe = 32'h10;
    for (int i = 0; i < 5; i++) begin
      expect_v("no_trap_mie0", 0);
      #1;
      compare(32'(epc_taken));
      tick();
    end
    instr_valid = 1'b0;
    rd("mip_meip", 12'h344, 32'h0000_0800);
    ext_irq = 1'b0;
    repeat (SYNC_STAGES + 2) tick();
    rd("mip_clear", 12'h344, 32'h0);

    // CSR read/modify/write
    wr(2'b01, 12'h340, 32'hA5A5_0000);
    rd("rw_mscratch", 12'h340, 32'hA5A5_0000);
    instr_valid = 1'b1; csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 32'h0000_00FF;
    expect_v("rs_old_rdata", 32'hA5A5_0000);
    #1;
    compare(csr_rdata);
    tick();
    instr_valid = 1'b0; csr_op = 2'b00;
    rd("rs_mscratch", 12'h340, 32'hA5A5_00FF);
    wr(2'b10, 12'h340, 32'h0);
    rd("rs_zero", 12'h340, 32'hA5A5_00FF);
    wr(2'b11, 12'h340, 32'hA500_0000);
    rd("rc_mscratch", 12'h340, 32'h00A5_00FF);
    wr(2'b01, 12'h7C0, 32'hFFFF_FFFF);
    rd("unimpl_read", 12'h7C0, 32'h0);
    wr(2'b01, 12'h344, 32'hFFFF_FFFF);
    rd("mip_ro", 12'h344, 32'h0);
    wr(2'b01, 12'h341, 32'h0000_1237);
    rd("mepc_align", 12'h341, 32'h0000_1234);
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd("mie_bits", 12'h304, 32'h0000_0880);
    wr(2'b01, 12'h304, 32'h0);
    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd("mstatus_bits", 12'h300, 32'h0000_0088);
    wr(2'b01, 12'h300, 32'h0);

    // Direct timer trap
    wr(2'b01, 12'h305, 32'h0000_0100);
    wr(2'b01, 12'h304, 32'h0000_0080);
    wr(2'b01, 12'h300, 32'h0000_0008);
    timer_irq = 1'b1; instr_valid = 1'b1; pc_exe = 32'h44;
    expect_v("tmr_before_mtip", 0);
    #1;
    compare(32'(epc_taken));
    tick();
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h0000_DEAD;
    expect_v("tmr_epc_taken", 1); expect_v("tmr_epc", 32'h100); expect_v("tmr_flush", 1);
    #1;
    compare(32'(epc_taken)); compare(epc); compare(32'(flush));
    tick();
    csr_wdata = 32'h0000_1111;
    expect_v("trapst_flush", 1); expect_v("trapst_epc_taken", 0);
    #1;
    compare(32'(flush)); compare(32'(epc_taken));
    tick();
    instr_valid = 1'b0; csr_op = 2'b00; timer_irq = 1'b0;
    expect_v("post_flush", 0); expect_v("post_epc_taken", 0); expect_v("idle_epc", 32'h44);
    #1;
    compare(32'(flush)); compare(32'(epc_taken)); compare(epc);
    rd("tmr_mepc", 12'h341, 32'h44);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mstatus", 12'h300, 32'h0000_0080);
    rd("csr_wr_suppressed", 12'h340, 32'h00A5_00FF);

    // mret blocked by branch, then mret
    instr_valid = 1'b1; is_mret = 1'b1; br_true = 1'b1;
    expect_v("mret_br_taken", 0); expect_v("mret_br_flush", 0);
    #1;
    compare(32'(epc_taken)); compare(32'(flush));
    tick();
    br_true = 1'b0; is_mret = 1'b0; instr_valid = 1'b0;
    rd("mret_br_mstatus", 12'h300, 32'h0000_0080);
    instr_valid = 1'b1; is_mret = 1'b1;
    expect_v("mret_taken", 1); expect_v("mret_epc", 32'h44); expect_v("mret_flush", 1);
    #1;
    compare(32'(epc_taken)); compare(epc); compare(32'(flush));
    tick();
    is_mret = 1'b0; instr_valid = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_0088);

    // Vectored, both pending, deferred by branch then jump
    wr(2'b01, 12'h305, 32'h0000_0201);
    wr(2'b01, 12'h304, 32'h0000_0880);
    timer_irq = 1'b1; ext_irq = 1'b1;
    repeat (SYNC_STAGES + 2) tick();
    instr_valid = 1'b1; br_true = 1'b1; pc_exe = 32'h60;
    expect_v("defer_br_taken", 0); expect_v("defer_br_flush", 0);
    #1;
    compare(32'(epc_taken)); compare(32'(flush));
    tick();
    br_true = 1'b0; jump_en = 1'b1; pc_exe = 32'h64;
    expect_v("defer_jmp_taken", 0);
    #1;
    compare(32'(epc_taken));
    tick();
    jump_en = 1'b0; pc_exe = 32'h68;
    expect_v("vec_taken", 1); expect_v("vec_epc", 32'h22C); expect_v("vec_flush", 1);
    #1;
    compare(32'(epc_taken)); compare(epc); compare(32'(flush));
    tick();
    instr_valid = 1'b0;
    tick();
    rd("vec_mepc", 12'h341, 32'h68);
    rd("vec_mcause", 12'h342, 32'h8000_000B);
    rd("vec_mstatus", 12'h300, 32'h0000_0080);

    // ext_irq to epc_taken latency, then reset in the trap cycle
    timer_irq = 1'b0; ext_irq = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    instr_valid = 1'b1; is_mret = 1'b1;
    expect_v("mret2_epc", 32'h68);
    #1;
    compare(epc);
    tick();
    is_mret = 1'b0; pc_exe = 32'h90; ext_irq = 1'b1;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (epc_taken) begin
        lat = k + 1;
        break;
      end
      tick();
    end
    expect_v("ext_latency_cycles", 32'(SYNC_STAGES + 2));
    compare(32'(lat));
    expect_v("ext_only_epc", 32'h22C);
    compare(epc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; instr_valid = 1'b0; ext_irq = 1'b0;
    expect_v("rst_midtrap_flush", 0);
    #1;
    compare(32'(flush));
    rd("rst_midtrap_mepc", 12'h341, 32'h0);
    rd("rst_midtrap_mstatus", 12'h300, 32'h0);

    if (exp_q.size() != 0) begin
      errs++;
      $error("FAIL sb_leftover: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
